midi_msg_sched: RTL and testbench
=================================

# midi_msg_sched

Round-robin scheduler that shares one MIDI byte transmitter among `N_REQ` message sources (button scanners, encoders, sequencers). Each requester presents a complete channel message (status, data1, data2). The scheduler grants one requester at a time, latches its message and acknowledges it. It then streams 2 or 3 bytes to the downstream 31250-baud serialiser over a valid/ready handshake. Running-status compression with idle timeout reduces wire time. The block sits between the message generators and the UART-style MIDI serialiser.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `RUNNING_STATUS`, 1: 1 = omit repeated status bytes; 0 = always send status.
- `RS_TIMEOUT`, 5_000_000: idle clk cycles after which running status is invalidated (50 ms at 100 MHz); counter is 23 bits.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  per-requester request level.
- `msg_status`  in  8*N_REQ  status byte of requester i at [8i+7:8i].
- `msg_data1`  in  8*N_REQ  first data byte, same packing.
- `msg_data2`  in  8*N_REQ  second data byte, same packing; ignored for 2-byte messages.
- `ack`  out  N_REQ  one-cycle pulse on bit i when requester i's message is latched.
- `err`  out  1  one-cycle pulse, coincident with `ack`, when the latched message is dropped as invalid.
- `grant_id`  out  3  index of the last granted requester.
- `busy`  out  1  high from grant until the last byte transfers.
- `tx_byte`  out  8  byte to serialiser.
- `tx_valid`  out  1  `tx_byte` is valid.
- `tx_ready`  in  1  serialiser accepts the byte on this edge.

## Operation
- States are IDLE, SEND_STAT, SEND_D1, SEND_D2.
- **IDLE:** if any `req` bit is high, select the first set bit searching from `last_grant+1` upward, wrapping modulo `N_REQ`.
  - Latch that requester's three bytes, pulse `ack[i]`, set `grant_id`/`last_grant` to i and raise `busy`.
  - `last_grant` resets to `N_REQ-1`, so requester 0 wins first.
- **Validation at grant:**
  - Status with bit7=0, or status ≥ 0xF0, is dropped. `err` pulses with `ack`, no bytes are sent, state stays IDLE, `busy` stays 0.
  - Data bytes have bit7 forced to 0.
- **Length:**
  - Status high nibble 0xC or 0xD gives 2 bytes; the D2 state is skipped.
  - All other valid statuses give 3 bytes.
- **Running status:**
  - If `RUNNING_STATUS`=1, `rs_valid`=1 and status equals `last_status`, go straight to SEND_D1; otherwise go to SEND_STAT.
  - On a status-byte transfer, `last_status` takes the status and `rs_valid` is set to 1.
- **Transitions:**
  - A transfer is an edge with `tx_valid && tx_ready`.
  - After the final byte transfers, return to IDLE.
- **Timeout:**
  - The idle counter resets to 0 on every transfer and otherwise increments, saturating.
  - When it reaches `RS_TIMEOUT`, `rs_valid` is cleared.
- A requester holding `req` high after `ack` is treated as presenting a new message and re-enters arbitration in normal rotation.
- **Reset:**
  - Asserting `rst` at any time aborts the current message mid-stream; the partial message is never resumed.
  - Reset values: `tx_valid`=0, `tx_byte`=0, `ack`=0, `err`=0, `busy`=0, `grant_id`=0.
  - Internal reset values: state IDLE, `rs_valid`=0, `last_status`=0, idle counter 0.

## Timing
- `req` sampled high at edge k: `ack`, `busy` and `tx_valid` (with the first byte) are all high in the cycle after edge k.
- `tx_byte` is stable while `tx_valid`=1 and `tx_ready`=0; `tx_valid` never drops without a transfer.
- Back-to-back within a message:
  - On a transfer edge, `tx_byte` updates to the next byte and `tx_valid` stays 1, with no bubble.
  - After the final byte, `tx_valid`=0 for at least one cycle (the IDLE arbitration cycle).
- `busy` falls on the final transfer edge.
- Minimum message period is (bytes + 1) cycles with `tx_ready` tied high.
- `req` arriving while not IDLE is held off until the next IDLE cycle; no request is lost while the level is held.
- The timeout clears `rs_valid` on the edge the counter equals `RS_TIMEOUT`. A grant in that same cycle uses the pre-clear value.

## Test plan
- **Single message:** req[0] with 0xB0/0x2E/0x7F and `tx_ready`=1 → `ack[0]` one cycle; bytes 0xB0, 0x2E, 0x7F on three consecutive edges; `busy` low after.
- **Running status:** the same requester sends 0xB0/0x2F/0x7F twice → second message transfers only 0x2F, 0x7F. With `RUNNING_STATUS`=0, all 6 bytes are sent.
- **Round robin:** req = 4'b1111 held for four messages → grant order 0, 1, 2, 3; then re-raise req[2] and req[0] → grant 0 then 2.
- **Lengths and validation:**
  - 0xC1/0x05 → 2 bytes (0xC1, 0x05).
  - 0x40 status → `ack`+`err`, no `tx_valid`.
  - Data 0xFF → sent as 0x7F.
- **Backpressure and timeout:**
  - `tx_ready` low for 100 cycles mid-message → `tx_byte` stable, no skipped byte.
  - With `RS_TIMEOUT`=50, idle 60 cycles then resend the same status → status byte retransmitted.
- **Reset mid-message:** pull `rst` low after the first byte → all outputs are at reset values immediately. The next message after release sends its status byte even if it matches the pre-reset status.

Source files
------------

// File: rtl/midi_msg_sched_if.sv
// Bundle of request-side and serialiser-side signals for midi_msg_sched.
//   req/msg_status/msg_data1/msg_data2 : message sources (byte i at [8i+7:8i])
//   ack/err/grant_id/busy              : per-grant status back to the sources
//   tx_byte/tx_valid/tx_ready          : valid/ready stream to the MIDI serialiser
// The master modport is the environment (sources + serialiser); the slave
// modport is the scheduler itself.
interface midi_msg_sched_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] msg_status;
  logic [8*N_REQ-1:0] msg_data1;
  logic [8*N_REQ-1:0] msg_data2;
  logic [N_REQ-1:0]   ack;
  logic               err;
  logic [2:0]         grant_id;
  logic               busy;
  logic [7:0]         tx_byte;
  logic               tx_valid;
  logic               tx_ready;

  modport master (
    output req, msg_status, msg_data1, msg_data2, tx_ready,
    input  ack, err, grant_id, busy, tx_byte, tx_valid
  );

  modport slave (
    input  req, msg_status, msg_data1, msg_data2, tx_ready,
    output ack, err, grant_id, busy, tx_byte, tx_valid
  );
endinterface

// File: rtl/midi_msg_sched.sv
// Round-robin scheduler sharing one MIDI byte serialiser among N_REQ message
// sources, with running-status compression and an idle timeout that
// invalidates the remembered status.
//   clk : system clock
//   rst : asynchronous, active-low reset
//   bus : midi_msg_sched_if.slave (requests in, ack/err/grant_id/busy out,
//         tx_byte/tx_valid out, tx_ready in)
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | arbitrate; latch, validate and acknowledge the winner
// SEND_STAT | status byte presented on tx_byte
// SEND_D1   | first data byte presented
// SEND_D2   | second data byte presented (3-byte messages only)
module midi_msg_sched #(
  parameter int N_REQ          = 4,
  parameter bit RUNNING_STATUS = 1'b1,
  parameter int RS_TIMEOUT     = 5_000_000
) (
  input logic             clk,
  input logic             rst,
  midi_msg_sched_if.slave bus
);

  localparam logic [22:0] RS_TIMEOUT_C = 23'(RS_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND_STAT = 2'd1,
    S_SEND_D1   = 2'd2,
    S_SEND_D2   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [2:0]       grant_id_q, grant_id_d;
  logic [2:0]       last_grant_q, last_grant_d;
  logic [7:0]       d1_q, d1_d;
  logic [7:0]       d2_q, d2_d;
  logic             len2_q, len2_d;
  logic [7:0]       last_status_q, last_status_d;
  logic             rs_valid_q, rs_valid_d;
  logic [22:0]      idle_cnt_q, idle_cnt_d;

  // Zero-padded copies so the winner can be selected with a 3-bit index
  // regardless of N_REQ.
  logic [7:0]  req_ext;
  logic [63:0] stat_ext, d1_ext, d2_ext;
  logic [3:0]  cand;
  logic        gnt_found;
  logic [2:0]  gnt_idx;
  logic [7:0]  g_status, g_d1, g_d2;
  logic        g_invalid, g_len2, rs_hit, xfer;
  logic [7:0]  ack_ext;

  assign req_ext  = 8'(bus.req);
  assign stat_ext = 64'(bus.msg_status);
  assign d1_ext   = 64'(bus.msg_data1);
  assign d2_ext   = 64'(bus.msg_data2);

  // Rotating priority: first set request strictly after last_grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_grant_q} + 4'(k);
      if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
      if (!gnt_found && req_ext[cand[2:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[2:0];
      end
    end
  end

  assign g_status  = stat_ext[{gnt_idx, 3'b000} +: 8];
  assign g_d1      = {1'b0, d1_ext[{gnt_idx, 3'b000} +: 7]};
  assign g_d2      = {1'b0, d2_ext[{gnt_idx, 3'b000} +: 7]};
  assign g_invalid = !g_status[7] || (g_status >= 8'hF0);
  assign g_len2    = (g_status[7:4] == 4'hC) || (g_status[7:4] == 4'hD);
  // rs_valid_q is the pre-clear value, so a grant on the timeout edge still
  // benefits from running status.
  assign rs_hit    = RUNNING_STATUS && rs_valid_q && (g_status == last_status_q);
  assign xfer      = tx_valid_q && bus.tx_ready;
  assign ack_ext   = 8'b1 << gnt_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ack_q         <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_byte_q     <= '0;
      grant_id_q    <= '0;
      last_grant_q  <= 3'(N_REQ - 1);
      d1_q          <= '0;
      d2_q          <= '0;
      len2_q        <= 1'b0;
      last_status_q <= '0;
      rs_valid_q    <= 1'b0;
      idle_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      tx_valid_q    <= tx_valid_d;
      tx_byte_q     <= tx_byte_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      d1_q          <= d1_d;
      d2_q          <= d2_d;
      len2_q        <= len2_d;
      last_status_q <= last_status_d;
      rs_valid_q    <= rs_valid_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found && !g_invalid) state_d = rs_hit ? S_SEND_D1 : S_SEND_STAT;
      end
      S_SEND_STAT: if (xfer) state_d = S_SEND_D1;
      S_SEND_D1:   if (xfer) state_d = len2_q ? S_IDLE : S_SEND_D2;
      S_SEND_D2:   if (xfer) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d        = '0;
    err_d        = 1'b0;
    busy_d       = busy_q;
    tx_valid_d   = tx_valid_q;
    tx_byte_d    = tx_byte_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    len2_d       = len2_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          ack_d        = ack_ext[N_REQ-1:0];
          grant_id_d   = gnt_idx;
          last_grant_d = gnt_idx;
          if (g_invalid) begin
            err_d = 1'b1;
          end else begin
            busy_d     = 1'b1;
            tx_valid_d = 1'b1;
            tx_byte_d  = rs_hit ? g_d1 : g_status;
            d1_d       = g_d1;
            d2_d       = g_d2;
            len2_d     = g_len2;
          end
        end
      end
      S_SEND_STAT: if (xfer) tx_byte_d = d1_q;
      S_SEND_D1: begin
        if (xfer) begin
          if (len2_q) begin
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
          end else begin
            tx_byte_d = d2_q;
          end
        end
      end
      S_SEND_D2: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Running-status memory and idle timer. A status transfer re-arms
  // rs_valid even if the timer happens to expire on the same edge.
  always_comb begin
    last_status_d = last_status_q;
    rs_valid_d    = rs_valid_q;
    idle_cnt_d    = idle_cnt_q;
    if (xfer) idle_cnt_d = '0;
    else if (idle_cnt_q != RS_TIMEOUT_C) idle_cnt_d = idle_cnt_q + 23'd1;
    if (idle_cnt_q == RS_TIMEOUT_C) rs_valid_d = 1'b0;
    if (state_q == S_SEND_STAT && xfer) begin
      last_status_d = tx_byte_q;
      rs_valid_d    = 1'b1;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;
  assign bus.tx_byte  = tx_byte_q;
  assign bus.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_midi_msg_sched.sv
// Scoreboard bench for midi_msg_sched: a running-status instance with a short
// timeout (dut) and a no-running-status instance (dut_nrs).
module tb_midi_msg_sched;
  localparam int N = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   prev_ack_cyc;
  logic rr_phase;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [3:0] exp_ack[$];

  midi_msg_sched_if #(.N_REQ(N)) bus_a ();
  midi_msg_sched_if #(.N_REQ(N)) bus_b ();

  midi_msg_sched #(.N_REQ(N), .RUNNING_STATUS(1'b1), .RS_TIMEOUT(50)) dut (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  midi_msg_sched #(.N_REQ(N), .RUNNING_STATUS(1'b0), .RS_TIMEOUT(50)) dut_nrs (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus_a.tx_valid && bus_a.tx_ready) begin
        if (exp_a.size() == 0) chk("byte_a_extra", 32'(exp_a.size()), 32'd1);
        else chk("byte_a", 32'(bus_a.tx_byte), 32'(exp_a.pop_front()));
      end
      if (bus_b.tx_valid && bus_b.tx_ready) begin
        if (exp_b.size() == 0) chk("byte_b_extra", 32'(exp_b.size()), 32'd1);
        else chk("byte_b", 32'(bus_b.tx_byte), 32'(exp_b.pop_front()));
      end
      if (|bus_a.ack || bus_a.err) begin
        if (exp_ack.size() == 0) chk("ack_extra", 32'(exp_ack.size()), 32'd1);
        else begin
          logic [3:0] ea;
          ea = exp_ack.pop_front();
          chk("ack_vec", 32'(bus_a.ack), 32'(4'b0001 << ea[2:0]));
          chk("ack_err", 32'(bus_a.err), 32'(ea[3]));
          chk("grant_id", 32'(bus_a.grant_id), 32'(ea[2:0]));
          if (rr_phase) begin
            if (prev_ack_cyc >= 0) chk("rr_period", 32'(cyc - prev_ack_cyc), 32'd4);
            prev_ack_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic set_msg(input int i, input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
    bus_a.msg_status[8*i +: 8] = s;
    bus_a.msg_data1[8*i +: 8]  = d1;
    bus_a.msg_data2[8*i +: 8]  = d2;
  endtask

  task automatic exp3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_a.push_back(a);
    exp_a.push_back(b);
    exp_a.push_back(c);
  endtask

  task automatic exp2(input logic [7:0] a, input logic [7:0] b);
    exp_a.push_back(a);
    exp_a.push_back(b);
  endtask

  // Called just after an edge; req is sampled at the next edge and the task
  // returns 1 ns after it, when ack/busy/first byte are visible.
  task automatic start_msg(input int i, input logic [7:0] s, input logic [7:0] d1,
                           input logic [7:0] d2, input logic e);
    set_msg(i, s, d1, d2);
    exp_ack.push_back({e, 3'(i)});
    bus_a.req[i] = 1'b1;
    @(posedge clk); #1;
    bus_a.req[i] = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int c;
    c = 0;
    while (bus_a.busy && c < max_cyc) begin
      @(posedge clk); #1;
      c++;
    end
    if (bus_a.busy) chk("idle_timeout", 32'(bus_a.busy), 32'd0);
  endtask

  task automatic hold_req(input logic [3:0] m, input int n);
    int got;
    int c;
    got = 0;
    c = 0;
    bus_a.req = m;
    while (got < n && c < 200) begin
      @(posedge clk); #1;
      c++;
      if (|bus_a.ack) got++;
    end
    bus_a.req = '0;
    if (got < n) chk("hold_timeout", 32'(got), 32'(n));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tx_valid"}, 32'(bus_a.tx_valid), 32'd0);
    chk({tag, "_tx_byte"},  32'(bus_a.tx_byte),  32'd0);
    chk({tag, "_ack"},      32'(bus_a.ack),      32'd0);
    chk({tag, "_err"},      32'(bus_a.err),      32'd0);
    chk({tag, "_busy"},     32'(bus_a.busy),     32'd0);
    chk({tag, "_grant_id"}, 32'(bus_a.grant_id), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int c;
    checks = 0;
    errors = 0;
    cyc = 0;
    prev_ack_cyc = -1;
    rr_phase = 1'b0;
    rst = 1'b0;
    bus_a.req = '0;
    bus_a.msg_status = '0;
    bus_a.msg_data1 = '0;
    bus_a.msg_data2 = '0;
    bus_a.tx_ready = 1'b1;
    bus_b.req = '0;
    bus_b.msg_status = '0;
    bus_b.msg_data1 = '0;
    bus_b.msg_data2 = '0;
    bus_b.tx_ready = 1'b1;
    #12;
    chk_reset("rst");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single message with first-byte latency checks
    exp3(8'hB0, 8'h2E, 8'h7F);
    start_msg(0, 8'hB0, 8'h2E, 8'h7F, 1'b0);
    chk("t1_busy", 32'(bus_a.busy), 32'd1);
    chk("t1_valid", 32'(bus_a.tx_valid), 32'd1);
    chk("t1_byte", 32'(bus_a.tx_byte), 32'hB0);
    wait_idle(20);
    chk("t1_busy_low", 32'(bus_a.busy), 32'd0);
    chk("t1_gap", 32'(bus_a.tx_valid), 32'd0);

    // Running status: same status twice -> data bytes only
    exp2(8'h2F, 8'h7F);
    start_msg(0, 8'hB0, 8'h2F, 8'h7F, 1'b0);
    wait_idle(20);
    exp2(8'h2F, 8'h7F);
    start_msg(0, 8'hB0, 8'h2F, 8'h7F, 1'b0);
    wait_idle(20);

    // Lengths and validation
    exp2(8'hC1, 8'h05);
    start_msg(0, 8'hC1, 8'h05, 8'h77, 1'b0);
    wait_idle(20);
    start_msg(1, 8'h40, 8'h01, 8'h02, 1'b1);
    chk("inv_busy", 32'(bus_a.busy), 32'd0);
    chk("inv_valid", 32'(bus_a.tx_valid), 32'd0);
    @(posedge clk); #1;
    chk("inv_valid2", 32'(bus_a.tx_valid), 32'd0);
    start_msg(1, 8'hF8, 8'h01, 8'h02, 1'b1);
    chk("sys_busy", 32'(bus_a.busy), 32'd0);
    exp3(8'h90, 8'h7F, 8'h7F);
    start_msg(0, 8'h90, 8'hFF, 8'hFF, 1'b0);
    wait_idle(20);

    // Round robin: anchor last grant at 3, then all four held
    exp3(8'hA3, 8'h01, 8'h02);
    start_msg(3, 8'hA3, 8'h01, 8'h02, 1'b0);
    wait_idle(20);
    for (int i = 0; i < 4; i++) begin
      set_msg(i, 8'h80 + 8'(i), 8'h10 + 8'(i), 8'h20 + 8'(i));
      exp3(8'h80 + 8'(i), 8'h10 + 8'(i), 8'h20 + 8'(i));
      exp_ack.push_back({1'b0, 3'(i)});
    end
    rr_phase = 1'b1;
    prev_ack_cyc = -1;
    hold_req(4'b1111, 4);
    wait_idle(20);
    exp3(8'h80, 8'h10, 8'h20);
    exp3(8'h82, 8'h12, 8'h22);
    exp_ack.push_back(4'd0);
    exp_ack.push_back(4'd2);
    prev_ack_cyc = -1;
    hold_req(4'b0101, 2);
    wait_idle(20);
    rr_phase = 1'b0;

    // Backpressure: stall 100 cycles on the first data byte
    exp3(8'hE1, 8'h11, 8'h22);
    start_msg(1, 8'hE1, 8'h11, 8'h22, 1'b0);
    @(posedge clk); #1;
    bus_a.tx_ready = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus_a.tx_byte !== 8'h11 || bus_a.tx_valid !== 1'b1) bad++;
    end
    chk("bp_unstable_cycles", 32'(bad), 32'd0);
    @(posedge clk); #1;
    bus_a.tx_ready = 1'b1;
    wait_idle(20);

    // The 100-cycle stall outlasted the timeout, so status is resent
    exp3(8'hE1, 8'h33, 8'h44);
    start_msg(1, 8'hE1, 8'h33, 8'h44, 1'b0);
    wait_idle(20);
    // Grant on the timeout edge still uses running status
    repeat (50) @(posedge clk);
    #1;
    exp2(8'h35, 8'h46);
    start_msg(1, 8'hE1, 8'h35, 8'h46, 1'b0);
    wait_idle(20);
    // One cycle later the status has expired
    repeat (51) @(posedge clk);
    #1;
    exp3(8'hE1, 8'h37, 8'h48);
    start_msg(1, 8'hE1, 8'h37, 8'h48, 1'b0);
    wait_idle(20);
    repeat (60) @(posedge clk);
    #1;
    exp3(8'hE1, 8'h39, 8'h4A);
    start_msg(1, 8'hE1, 8'h39, 8'h4A, 1'b0);
    wait_idle(20);

    // Reset after the first byte of a message
    exp_a.push_back(8'hB0);
    start_msg(2, 8'hB0, 8'h01, 8'h02, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_reset("mid_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    set_msg(0, 8'hB0, 8'h03, 8'h04);
    set_msg(1, 8'h91, 8'h05, 8'h06);
    set_msg(3, 8'h93, 8'h07, 8'h08);
    exp3(8'hB0, 8'h03, 8'h04);
    exp_ack.push_back(4'd0);
    hold_req(4'b1011, 1);
    wait_idle(20);

    // No running status: every message carries its status byte
    for (int m = 0; m < 2; m++) begin
      exp_b.push_back(8'hB0);
      exp_b.push_back(8'h2F);
      exp_b.push_back(8'h7F);
      bus_b.msg_status[7:0] = 8'hB0;
      bus_b.msg_data1[7:0]  = 8'h2F;
      bus_b.msg_data2[7:0]  = 8'h7F;
      bus_b.req[0] = 1'b1;
      @(posedge clk); #1;
      bus_b.req[0] = 1'b0;
      c = 0;
      while (bus_b.busy && c < 20) begin
        @(posedge clk); #1;
        c++;
      end
      if (bus_b.busy) chk("nrs_idle_timeout", 32'(bus_b.busy), 32'd0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("left_bytes_a", 32'(exp_a.size()), 32'd0);
    chk("left_bytes_b", 32'(exp_b.size()), 32'd0);
    chk("left_acks", 32'(exp_ack.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
